// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronises, glitch-filters and Gray-decodes
// the raw A/B/button pins into single-cycle up/down/load/err command pulses.
module quad_step_decoder #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned FILTER_W   = 3,
    parameter int unsigned ARM_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    input  logic enc_btn,
    output logic up,
    output logic down,
    output logic load,
    output logic err
);

    localparam int unsigned ArmW = $clog2(ARM_CYCLES + 1);

    // Channel bit positions within the 3-bit input vectors
    localparam int unsigned ChA   = 2;
    localparam int unsigned ChB   = 1;
    localparam int unsigned ChBtn = 0;

    typedef enum logic [1:0] {
        StepNone,
        StepUp,
        StepDown,
        StepErr
    } step_e;

    logic [2:0]          w_raw;
    logic [2:0]          r_sync1;
    logic [2:0]          r_sync2;
    logic [2:0]          r_filt;
    logic [2:0]          w_filt_d;
    logic [FILTER_W-1:0] r_cnt   [3];
    logic [FILTER_W-1:0] w_cnt_d [3];
    logic [1:0]          r_state;
    logic                r_btn_prev;
    logic [ArmW-1:0]     r_arm_cnt;
    logic                w_armed;
    step_e               w_step;
    logic                r_up;
    logic                r_down;
    logic                r_err;
    logic                r_load;

    assign w_raw   = {enc_a, enc_b, enc_btn};
    assign w_armed = (r_arm_cnt == ArmW'(ARM_CYCLES));

    // Two-flop synchronisers for all raw pins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Filter next state: accept a new level only after FILTER_LEN differing samples
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_filt_d[i] = r_filt[i];
            w_cnt_d[i]  = '0;
            if (r_sync2[i] != r_filt[i]) begin
                if (r_cnt[i] == FILTER_W'(FILTER_LEN - 1)) begin
                    w_filt_d[i] = r_sync2[i];
                end else begin
                    w_cnt_d[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Filtered values and their run counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_filt <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_filt <= w_filt_d;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
        end
    end

    // Gray decode of previous {a,b} against the current filtered {a,b}
    always_comb begin
        w_step = StepNone;
        case ({r_state, r_filt[ChA], r_filt[ChB]})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_step = StepUp;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_step = StepDown;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_step = StepErr;
            default:                                 w_step = StepNone;
        endcase
    end

    // Arm counter saturates once the post-reset quiet period has elapsed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_arm_cnt <= '0;
        end else if (!w_armed) begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
        end
    end

    // Decoder history tracks filtered values even while unarmed; pulses are gated by arming
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= '0;
            r_btn_prev <= 1'b0;
            r_up       <= 1'b0;
            r_down     <= 1'b0;
            r_err      <= 1'b0;
            r_load     <= 1'b0;
        end else begin
            r_state    <= {r_filt[ChA], r_filt[ChB]};
            r_btn_prev <= r_filt[ChBtn];
            r_up       <= w_armed && (w_step == StepUp);
            r_down     <= w_armed && (w_step == StepDown);
            r_err      <= w_armed && (w_step == StepErr);
            r_load     <= w_armed && r_filt[ChBtn] && !r_btn_prev;
        end
    end

    assign up   = r_up;
    assign down = r_down;
    assign err  = r_err;
    assign load = r_load;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench for quad_step_decoder: directed scenarios plus a random
// phase, all compared every cycle against a window/Gray-position reference model.
module tb_quad_step_decoder;

    localparam int FL  = 4;
    localparam int ARM = 8;
    localparam int LAT = FL + 3;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic enc_a   = 1'b0;
    logic enc_b   = 1'b0;
    logic enc_btn = 1'b0;
    logic up;
    logic down;
    logic load;
    logic err;

    always #5 clk = ~clk;

    quad_step_decoder #(
        .FILTER_LEN (FL),
        .FILTER_W   (3),
        .ARM_CYCLES (ARM)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .enc_btn (enc_btn),
        .up      (up),
        .down    (down),
        .load    (load),
        .err     (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Raw sample history: bit k holds the pin value sampled k+1 edges ago.
    logic [FL:0] m_sh_a, m_sh_b, m_sh_btn;
    logic        m_fa, m_fb, m_fbtn;
    logic [1:0]  m_ab_prev;
    logic        m_btn_prev;
    int          m_edges;
    logic        exp_up, exp_down, exp_err, exp_load;

    // A filtered value flips once the last FL synchronised samples all disagree with it.
    // The synchronised sample seen at an edge is the raw sample from two edges earlier.
    function automatic logic filt_next(input logic [FL:0] sh, input logic f);
        logic [FL-1:0] win;
        win = sh[FL:1];
        return (win == {FL{~f}}) ? ~f : f;
    endfunction

    function automatic int gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // 1 = one step clockwise, 3 = one step counter-clockwise, 2 = illegal jump
    function automatic int move(input logic [1:0] o, input logic [1:0] n);
        return (gray_pos(n) - gray_pos(o) + 4) % 4;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_sh_a     <= '0;
            m_sh_b     <= '0;
            m_sh_btn   <= '0;
            m_fa       <= 1'b0;
            m_fb       <= 1'b0;
            m_fbtn     <= 1'b0;
            m_ab_prev  <= 2'b00;
            m_btn_prev <= 1'b0;
            m_edges    <= 0;
            exp_up     <= 1'b0;
            exp_down   <= 1'b0;
            exp_err    <= 1'b0;
            exp_load   <= 1'b0;
        end else begin
            exp_up     <= (m_edges >= ARM) && (move(m_ab_prev, {m_fa, m_fb}) == 1);
            exp_down   <= (m_edges >= ARM) && (move(m_ab_prev, {m_fa, m_fb}) == 3);
            exp_err    <= (m_edges >= ARM) && (move(m_ab_prev, {m_fa, m_fb}) == 2);
            exp_load   <= (m_edges >= ARM) && m_fbtn && !m_btn_prev;
            m_ab_prev  <= {m_fa, m_fb};
            m_btn_prev <= m_fbtn;
            m_fa       <= filt_next(m_sh_a, m_fa);
            m_fb       <= filt_next(m_sh_b, m_fb);
            m_fbtn     <= filt_next(m_sh_btn, m_fbtn);
            m_sh_a     <= {m_sh_a[FL-1:0], enc_a};
            m_sh_b     <= {m_sh_b[FL-1:0], enc_b};
            m_sh_btn   <= {m_sh_btn[FL-1:0], enc_btn};
            if (m_edges < ARM) m_edges <= m_edges + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 1'b0;
    int tot_up = 0, tot_down = 0, tot_err = 0, tot_load = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("up", int'(up), int'(exp_up));
            check("down", int'(down), int'(exp_down));
            check("err", int'(err), int'(exp_err));
            check("load", int'(load), int'(exp_load));
            check("excl", int'((int'(up) + int'(down) + int'(err)) <= 1), 1);
            tot_up   += int'(up);
            tot_down += int'(down);
            tot_err  += int'(err);
            tot_load += int'(load);
        end
    end

    // ---------------- stimulus helpers ----------------
    int s_up, s_down, s_err, s_load;

    task automatic snap();
        s_up   = tot_up;
        s_down = tot_down;
        s_err  = tot_err;
        s_load = tot_load;
    endtask

    task automatic check_counts(input string tag, input int eu, input int ed, input int ee,
                                input int el);
        check({tag, "_n_up"}, tot_up - s_up, eu);
        check({tag, "_n_down"}, tot_down - s_down, ed);
        check({tag, "_n_err"}, tot_err - s_err, ee);
        check({tag, "_n_load"}, tot_load - s_load, el);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive all pins at a falling edge, hold for 'hold' rising edges, and report the
    // rising edge (1-based) on which the first output pulse became visible, or -1.
    task automatic drive_lat(input logic [1:0] ab, input logic btn, input int hold,
                             output int lat);
        @(negedge clk);
        enc_a   = ab[1];
        enc_b   = ab[0];
        enc_btn = btn;
        lat     = -1;
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk);
            #1;
            if (lat < 0 && (up || down || err || load)) lat = k;
        end
    endtask

    task automatic do_reset(input logic [1:0] ab);
        @(negedge clk);
        enc_a   = ab[1];
        enc_b   = ab[0];
        enc_btn = 1'b0;
        reset   = 1'b0;
        cyc(3);
        reset = 1'b1;
        cyc(ARM + 6);
    endtask

    // Bound the whole run
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    logic [1:0] gray_tab [4];
    int         lat;

    initial begin
        gray_tab[0] = 2'b00;
        gray_tab[1] = 2'b01;
        gray_tab[2] = 2'b11;
        gray_tab[3] = 2'b10;
        #1;
        check("rst_outs", int'({up, down, err, load}), 0);
        cmp_en = 1'b1;

        // 1: clockwise cycle, x4 decoding
        do_reset(2'b00);
        snap();
        drive_lat(2'b01, 1'b0, 10, lat);
        check("s1_lat01", lat, LAT);
        drive_lat(2'b11, 1'b0, 10, lat);
        check("s1_lat11", lat, LAT);
        drive_lat(2'b10, 1'b0, 10, lat);
        drive_lat(2'b00, 1'b0, 10, lat);
        check("s1_lat00", lat, LAT);
        check_counts("s1", 4, 0, 0, 0);

        // 2: counter-clockwise cycle
        snap();
        drive_lat(2'b10, 1'b0, 10, lat);
        check("s2_lat10", lat, LAT);
        drive_lat(2'b11, 1'b0, 10, lat);
        drive_lat(2'b01, 1'b0, 10, lat);
        drive_lat(2'b00, 1'b0, 10, lat);
        check_counts("s2", 0, 4, 0, 0);

        // 3: short pulse and bounce on A are rejected
        snap();
        @(negedge clk);
        enc_a = 1'b1;
        cyc(3);
        enc_a = 1'b0;
        cyc(1);
        for (int i = 0; i < 20; i++) begin
            enc_a = (i % 2 == 0);
            cyc(1);
        end
        enc_a = 1'b0;
        cyc(10);
        check("s3_model_fa", int'(m_fa), 0);
        check_counts("s3", 0, 0, 0, 0);
        snap();
        drive_lat(2'b01, 1'b0, 10, lat);
        drive_lat(2'b00, 1'b0, 10, lat);
        check_counts("s3b", 1, 1, 0, 0);

        // 4: illegal double change, then a legal step
        snap();
        drive_lat(2'b11, 1'b0, 12, lat);
        check("s4_err_lat", lat, LAT);
        check_counts("s4a", 0, 0, 1, 0);
        snap();
        drive_lat(2'b10, 1'b0, 12, lat);
        check_counts("s4b", 1, 0, 0, 0);

        // 5: bouncy button press and release
        snap();
        @(negedge clk);
        enc_btn = 1'b1;
        @(negedge clk);
        enc_btn = 1'b0;
        drive_lat(2'b10, 1'b1, 30, lat);
        check("s5_load_lat", lat, LAT);
        @(negedge clk);
        enc_btn = 1'b0;
        @(negedge clk);
        enc_btn = 1'b1;
        drive_lat(2'b10, 1'b0, 30, lat);
        check("s5_release_lat", lat, -1);
        check_counts("s5", 0, 0, 0, 1);

        // 6: reset mid-rotation at 11
        drive_lat(2'b11, 1'b0, 12, lat);
        drive_lat(2'b10, 1'b0, 3, lat);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("s6_rst_outs", int'({up, down, err, load}), 0);
        enc_a = 1'b1;
        enc_b = 1'b1;
        cyc(3);
        reset = 1'b1;
        snap();
        cyc(ARM + 4);
        check_counts("s6_quiet", 0, 0, 0, 0);
        snap();
        drive_lat(2'b10, 1'b0, 12, lat);
        check("s6_up_lat", lat, LAT);
        check_counts("s6", 1, 0, 0, 0);

        // Random phase, checked every cycle by the compare process
        begin
            int         pos;
            logic       btn;
            logic [1:0] ab;
            pos = 3;
            btn = 1'b0;
            for (int it = 0; it < 250; it++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r <= 4) begin
                    pos = ($urandom_range(0, 1) != 0) ? (pos + 1) % 4 : (pos + 3) % 4;
                    drive_lat(gray_tab[pos], btn, $urandom_range(1, 12), lat);
                end else if (r == 5) begin
                    pos = (pos + 2) % 4;
                    drive_lat(gray_tab[pos], btn, $urandom_range(1, 12), lat);
                end else if (r == 6) begin
                    ab = gray_tab[pos] ^ 2'($urandom_range(1, 3));
                    drive_lat(ab, btn, $urandom_range(1, 5), lat);
                    drive_lat(gray_tab[pos], btn, $urandom_range(1, 8), lat);
                end else if (r == 7) begin
                    btn = ~btn;
                    drive_lat(gray_tab[pos], btn, $urandom_range(1, 15), lat);
                end else if (r == 8) begin
                    for (int c = 0; c < 10; c++) begin
                        @(negedge clk);
                        enc_a   = 1'($urandom_range(0, 1));
                        enc_b   = 1'($urandom_range(0, 1));
                        enc_btn = 1'($urandom_range(0, 1));
                    end
                    drive_lat(gray_tab[pos], btn, 12, lat);
                end else if ($urandom_range(0, 7) == 0) begin
                    @(negedge clk);
                    #2;
                    reset = 1'b0;
                    cyc(2);
                    reset = 1'b1;
                end else begin
                    cyc($urandom_range(1, 6));
                end
            end
        end

        cyc(20);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
